// File: rtl/i2c_master.sv
// Single-register write/read I2C master for one 7-bit addressed device.
// Each bus bit spans four i2c_clk cycles (q0..q3); scl is push-pull, sda open-drain.
module i2c_master #(
    parameter logic [6:0] SLAVE_ADDR = 7'h73
) (
    input  logic       i2c_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic       wr_rd,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_START      = 4'd1,
        ST_SEND_DEV_W = 4'd2,
        ST_ACK1       = 4'd3,
        ST_SEND_REG   = 4'd4,
        ST_ACK2       = 4'd5,
        ST_SEND_DATA  = 4'd6,
        ST_ACK3       = 4'd7,
        ST_RESTART    = 4'd8,
        ST_SEND_DEV_R = 4'd9,
        ST_ACK4       = 4'd10,
        ST_READ_DATA  = 4'd11,
        ST_NACK       = 4'd12,
        ST_STOP       = 4'd13
    } state_t;

    state_t     state_r, state_nxt_s;
    logic [1:0] q_r, q_nxt_s;
    logic [2:0] bit_cnt_r, bit_cnt_nxt_s;
    logic [7:0] tx_sr_r, tx_sr_nxt_s;
    logic [6:0] rx_sr_r;
    logic       wr_rd_r;
    logic [7:0] reg_addr_r;
    logic [7:0] wr_data_r;
    logic       sda_oe_r;
    logic       sda_in_s;
    logic       bit_end_s;
    logic       last_bit_s;
    logic       is_ack_s;
    logic       is_shift_s;
    logic       ack_miss_s;
    logic       accept_s;

    assign sda      = sda_oe_r ? 1'b0 : 1'bz;
    assign sda_in_s = sda;

    assign bit_end_s  = (state_r != ST_IDLE) && (q_r == 2'd3);
    assign last_bit_s = (bit_cnt_r == 3'd7);
    assign accept_s   = (state_r == ST_IDLE) && start;
    assign is_ack_s   = (state_r == ST_ACK1) || (state_r == ST_ACK2) ||
                        (state_r == ST_ACK3) || (state_r == ST_ACK4);
    assign is_shift_s = (state_r == ST_SEND_DEV_W) || (state_r == ST_SEND_REG) ||
                        (state_r == ST_SEND_DATA)  || (state_r == ST_SEND_DEV_R) ||
                        (state_r == ST_READ_DATA);
    assign ack_miss_s = bit_end_s && is_ack_s && sda_in_s;

    // scl level for a given state and quarter
    function automatic logic scl_level(input state_t st, input logic [1:0] q);
        case (st)
            ST_IDLE, ST_START:   scl_level = 1'b1;
            ST_RESTART, ST_STOP: scl_level = (q != 2'd0);
            default:             scl_level = q[1];
        endcase
    endfunction

    // 1 when sda must be pulled low for a given state, quarter and outgoing bit
    function automatic logic sda_low(input state_t st, input logic [1:0] q, input logic tx_bit);
        case (st)
            ST_START, ST_RESTART: sda_low = q[1];
            ST_STOP:              sda_low = ~q[1];
            ST_SEND_DEV_W, ST_SEND_REG, ST_SEND_DATA, ST_SEND_DEV_R:
                                  sda_low = ~tx_bit;
            default:              sda_low = 1'b0;
        endcase
    endfunction

    // Next-state, quarter, bit counter and transmit shifter
    always_comb begin
        state_nxt_s   = state_r;
        q_nxt_s       = q_r;
        bit_cnt_nxt_s = bit_cnt_r;
        tx_sr_nxt_s   = tx_sr_r;
        if (state_r == ST_IDLE) begin
            q_nxt_s       = 2'd0;
            bit_cnt_nxt_s = 3'd0;
            if (start) begin
                state_nxt_s = ST_START;
            end else begin
                state_nxt_s = ST_IDLE;
            end
        end else if (!bit_end_s) begin
            q_nxt_s = q_r + 2'd1;
        end else begin
            q_nxt_s = 2'd0;
            if (is_shift_s) begin
                bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                tx_sr_nxt_s   = {tx_sr_r[6:0], 1'b0};
            end else begin
                bit_cnt_nxt_s = 3'd0;
            end
            case (state_r)
                ST_START: begin
                    state_nxt_s = ST_SEND_DEV_W;
                    tx_sr_nxt_s = {SLAVE_ADDR, 1'b0};
                end
                ST_SEND_DEV_W: state_nxt_s = last_bit_s ? ST_ACK1 : ST_SEND_DEV_W;
                ST_ACK1: begin
                    if (sda_in_s) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        state_nxt_s = ST_SEND_REG;
                        tx_sr_nxt_s = reg_addr_r;
                    end
                end
                ST_SEND_REG: state_nxt_s = last_bit_s ? ST_ACK2 : ST_SEND_REG;
                ST_ACK2: begin
                    if (sda_in_s) begin
                        state_nxt_s = ST_STOP;
                    end else if (wr_rd_r) begin
                        state_nxt_s = ST_RESTART;
                    end else begin
                        state_nxt_s = ST_SEND_DATA;
                        tx_sr_nxt_s = wr_data_r;
                    end
                end
                ST_SEND_DATA: state_nxt_s = last_bit_s ? ST_ACK3 : ST_SEND_DATA;
                ST_ACK3:      state_nxt_s = ST_STOP;
                ST_RESTART: begin
                    state_nxt_s = ST_SEND_DEV_R;
                    tx_sr_nxt_s = {SLAVE_ADDR, 1'b1};
                end
                ST_SEND_DEV_R: state_nxt_s = last_bit_s ? ST_ACK4 : ST_SEND_DEV_R;
                ST_ACK4:       state_nxt_s = sda_in_s ? ST_STOP : ST_READ_DATA;
                ST_READ_DATA:  state_nxt_s = last_bit_s ? ST_NACK : ST_READ_DATA;
                ST_NACK:       state_nxt_s = ST_STOP;
                ST_STOP:       state_nxt_s = ST_IDLE;
                default:       state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM registers; bus pins are decoded from the next state so they align with it
    always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r    <= ST_IDLE;
            q_r        <= 2'd0;
            bit_cnt_r  <= 3'd0;
            tx_sr_r    <= 8'h00;
            rx_sr_r    <= 7'h00;
            wr_rd_r    <= 1'b0;
            reg_addr_r <= 8'h00;
            wr_data_r  <= 8'h00;
            scl        <= 1'b1;
            sda_oe_r   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ack_err    <= 1'b0;
            rd_data    <= 8'h00;
        end else begin
            state_r   <= state_nxt_s;
            q_r       <= q_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            tx_sr_r   <= tx_sr_nxt_s;
            scl       <= scl_level(state_nxt_s, q_nxt_s);
            sda_oe_r  <= sda_low(state_nxt_s, q_nxt_s, tx_sr_nxt_s[7]);
            busy      <= (state_nxt_s != ST_IDLE);
            done      <= bit_end_s && (state_r == ST_STOP);
            if (accept_s) begin
                wr_rd_r    <= wr_rd;
                reg_addr_r <= reg_addr;
                wr_data_r  <= wr_data;
                ack_err    <= 1'b0;
            end else if (ack_miss_s) begin
                ack_err <= 1'b1;
            end
            // rd_data only moves once the full byte has arrived
            if (bit_end_s && (state_r == ST_READ_DATA)) begin
                rx_sr_r <= {rx_sr_r[5:0], sda_in_s};
                if (last_bit_s) begin
                    rd_data <= {rx_sr_r, sda_in_s};
                end
            end
        end
    end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h73, the 7-bit device address sent in every transaction.
REQ-002 SHALL have port i2c_clk  input  1  the only clock, the divided I2C working clock (1 MHz nominal); all logic on its rising edge.
REQ-003 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  transaction request; sampled only while busy=0.
REQ-005 SHALL have port wr_rd  input  1  0 = register write, 1 = register read.
REQ-006 SHALL have port reg_addr  input  8  device register address.
REQ-007 SHALL have port wr_data  input  8  byte to write (ignored on read).
REQ-008 SHALL have port rd_data  output  8  byte read from device.
REQ-009 SHALL have port busy  output  1  high from the cycle after acceptance until the transaction ends.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port ack_err  output  1  high if any slave ACK was missing in the last transaction.
REQ-012 SHALL have port scl  output  1  I2C clock, push-pull.
REQ-013 SHALL have port sda  inout  1  I2C data, open-drain: drives 0 or high-Z only.

Function
REQ-014 SHALL time every bus bit as one bit period of 4 i2c_clk cycles, quarters q0..q3, using a 2-bit quarter counter that wraps 3->0.
REQ-015 SHALL drive scl=0 in q0-q1 and scl=1 in q2-q3 for data/ACK bits; SHALL change sda only at q0; SHALL sample sda at q3.
REQ-016 SHALL implement states IDLE, START, SEND_DEV_W, ACK1, SEND_REG, ACK2, SEND_DATA, ACK3, RESTART, SEND_DEV_R, ACK4, READ_DATA, NACK, STOP.
REQ-017 IDLE: scl=1, sda released; on start=1, SHALL latch wr_rd, reg_addr and wr_data, clear ack_err, and enter START with q=0 on the next cycle.
REQ-018 START: scl=1 in all quarters; sda released in q0-q1 and driven 0 in q2-q3.
REQ-019 RESTART: scl=0 in q0, 1 in q1-q3; sda released in q0-q1, driven 0 in q2-q3.
REQ-020 STOP: sda driven 0 in q0-q1 and released in q2-q3; scl=0 in q0, 1 in q1-q3.
REQ-021 SEND_* states SHALL shift 8 bits MSB first, one per bit period: {SLAVE_ADDR,0} for DEV_W, {SLAVE_ADDR,1} for DEV_R.
REQ-022 ACK1-4: sda released; a sample of 1 at q3 SHALL set ack_err and go to STOP; a sample of 0 SHALL continue.
REQ-023 Write sequence: START, SEND_DEV_W, ACK1, SEND_REG, ACK2, SEND_DATA, ACK3, STOP = 29 bit periods (116 cycles).
REQ-024 Read sequence: START, SEND_DEV_W, ACK1, SEND_REG, ACK2, RESTART, SEND_DEV_R, ACK4, READ_DATA, NACK, STOP = 39 bit periods (156 cycles).
REQ-025 READ_DATA SHALL release sda and shift the q3 samples in MSB first; rd_data SHALL update once, at the end of the 8th bit; NACK SHALL release sda (master NACK).
REQ-026 After STOP q3, SHALL return to IDLE; done=1 and busy=0 in that first IDLE cycle, i.e., on the 117th (write) or 157th (read) rising edge after the edge that sampled start.
REQ-027 start asserted while busy=1 SHALL be ignored; a start present in the done cycle SHALL be accepted.
REQ-028 ack_err and rd_data SHALL hold until the next accepted start; rd_data SHALL be unchanged by write or errored transactions.

Reset
REQ-029 sys_rst_n=0 SHALL asynchronously force state IDLE, q=0, scl=1, sda released, busy=0, done=0, ack_err=0, rd_data=8'h00, including mid-transaction.

Verification
REQ-030 Write with reg_addr=8'hEF, wr_data=8'h01, slave ACKs -> sda bytes E6, EF, 01 on scl rising edges; done after 116 cycles of busy; ack_err=0.
REQ-031 Read with reg_addr=8'h43, slave returns 8'hA5 -> bytes E6, 43, RESTART, E7; master NACK; rd_data=8'hA5; done after 156 cycles of busy.
REQ-032 Slave NACKs device address on a write -> ack_err=1; STOP directly after ACK1; done after 11 bit periods (44 cycles of busy).
REQ-033 start pulsed at cycle 20 of a running write -> ignored; exactly one done; second start in the done cycle begins a new START.
REQ-034 sys_rst_n low during SEND_REG -> immediately scl=1, sda=Z, busy=0; after release, a new write completes normally.
